i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk cycles per quarter SCL period (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, meaning single system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, meaning transaction request, sampled only when busy=0.
REQ-005 SHALL have port dev_addr, input, 7, meaning target 7-bit address, latched on accepted start.
REQ-006 SHALL have port reg_addr, input, 8, meaning register byte, latched on accepted start and used only per REQ-027.
REQ-007 SHALL have port wr_data, input, 8, meaning data byte (e.g. PWM duty), latched on accepted start.
REQ-008 SHALL have port scl, output, 1, meaning push-pull I2C clock to the bus.
REQ-009 SHALL have port sda, inout, 1, meaning open-drain I2C data; driven 0 or high-Z, never driven 1.
REQ-010 SHALL have port busy, output, 1, meaning transaction in progress.
REQ-011 SHALL have port done, output, 1, meaning one-cycle pulse at transaction end.
REQ-012 SHALL have port ack_err, output, 1, meaning last transaction saw a NACK; valid when done=1, held until next accepted start.

Function
REQ-013 SHALL generate a quarter tick every CLK_DIV clk cycles while busy=1; divider counter cleared on accepted start.
REQ-014 SHALL accept start when busy=0, assert busy on the next cycle, ignore start while busy=1.
REQ-015 SHALL use states IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, STOP, with each non-IDLE state advancing only on quarter ticks.
REQ-016 SHALL perform START in 2 quarters: Q0 SCL=1 with SDA released, then Q1 SCL=1 with SDA=0.
REQ-017 SHALL transmit each bit in 4 quarters: Q0 SCL=0 with SDA updated, Q1 SCL=0, Q2 SCL=1, Q3 SCL=1; MSB first.
REQ-018 SHALL send the address byte as {dev_addr, 1'b0} (write only).
REQ-019 SHALL release SDA for the 9th (ACK) bit and sample it at the end of Q2; 0 means ACK, 1 means NACK.
REQ-020 SHALL on NACK in any ACK state set ack_err=1 and go directly to STOP, skipping remaining bytes.
REQ-021 SHALL perform STOP in 3 quarters: SCL=0 with SDA=0, then SCL=1 with SDA=0, then SCL=1 with SDA released.
REQ-022 SHALL after STOP return to IDLE, deassert busy, and pulse done for exactly one cycle in that same cycle.
REQ-023 SHALL take exactly 77 quarters (without REQ-027) or 113 quarters (with it) from the first START quarter to done, when all bytes are ACKed.
REQ-024 SHALL hold SCL=1 with SDA released in IDLE.

Reset
REQ-025 SHALL on rst=1 immediately force: state IDLE, scl=1, sda high-Z, busy=0, done=0, ack_err=0, divider and bit counters 0.
REQ-026 SHALL abort a transaction on mid-operation reset without issuing STOP; the next transaction starts cleanly from IDLE.

Configuration
REQ-027 SHALL, when macro I2C_MASTER_REG_ADDR_EN is defined, insert REG and REG_ACK states that send reg_addr between ADDR_ACK and DATA.
REQ-028 SHALL, when I2C_MASTER_REG_ADDR_EN is undefined, go ADDR_ACK to DATA and ignore reg_addr; the port remains present.

Verification
REQ-029 SHALL pass this check: CLK_DIV=4, macro off, dev_addr=7'h42, wr_data=8'h80, responder ACKs -> bus bytes 8'h84, 8'h80; done 308 cycles after the first START quarter; ack_err=0.
REQ-030 SHALL pass this check: responder NACKs the address -> no data byte clocked; STOP follows; done with ack_err=1.
REQ-031 SHALL pass this check: macro on, reg_addr=8'h05, wr_data=8'h3C -> bus bytes 8'h84, 8'h05, 8'h3C; 452 cycles at CLK_DIV=4.
REQ-032 SHALL pass this check: start pulsed again while busy -> ignored; exactly one done pulse.
REQ-033 SHALL pass this check: rst asserted during DATA bit 3 -> scl=1, sda=Z, busy=0 in the same cycle; a subsequent start completes normally.
REQ-034 SHALL pass this check: loopback to i2cSlave (pwmGen duty) with wr_data=8'hC0 -> slave pwm_value=8'hC0 after done, and SDA never driven 1 by the master.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: write-only I2C master sending {dev_addr,0}, an optional reg_addr byte, then wr_data.
// Optional register byte is enabled by defining macro I2C_MASTER_REG_ADDR_EN.
// Ports: clk, rst (async, active-high), start/dev_addr/reg_addr/wr_data (request, latched on accept),
//        scl (push-pull), sda (open-drain: 0 or Z), busy, done (1-cycle pulse), ack_err (NACK seen).
module i2c_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);
    typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, STOP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  sh_q, sh_d, dat_q, dat_d;
    logic        nack_q, nack_d, scl_q, scl_d, oe_q, oe_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic        tick;
`ifdef I2C_MASTER_REG_ADDR_EN
    logic [7:0]  rga_q, rga_d;
`else
    logic        unused_reg;
    assign unused_reg = ^reg_addr;
`endif

    assign tick    = div_q == 16'(CLK_DIV - 1);
    assign sda     = oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = err_q;

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        dat_d   = dat_q;
        nack_d  = nack_q;
        err_d   = err_q;
        done_d  = 1'b0;
`ifdef I2C_MASTER_REG_ADDR_EN
        rga_d   = rga_q;
`endif
        // Divider idles at 0, so an accepted start always begins a fresh quarter.
        div_d = (state_q == IDLE || tick) ? 16'd0 : div_q + 16'd1;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = START;
                qtr_d   = 2'd0;
                bit_d   = 3'd7;
                sh_d    = {dev_addr, 1'b0};
                dat_d   = wr_data;
                err_d   = 1'b0;
`ifdef I2C_MASTER_REG_ADDR_EN
                rga_d   = reg_addr;
`endif
            end
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            case (state_q)
                START: if (qtr_q == 2'd1) begin
                    state_d = ADDR;
                    qtr_d   = 2'd0;
                end
                // bit counter wraps 0->7 so the next byte starts at its MSB
                ADDR, REG, DATA: if (qtr_q == 2'd3) begin
                    bit_d = bit_q - 3'd1;
                    sh_d  = {sh_q[6:0], 1'b0};
                    if (bit_q == 3'd0)
                        state_d = (state_q == ADDR) ? ADDR_ACK : (state_q == REG) ? REG_ACK : DATA_ACK;
                end
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    if (qtr_q == 2'd2) nack_d = sda;
                    if (qtr_q == 2'd3) begin
                        if (nack_q) begin
                            err_d   = 1'b1;
                            state_d = STOP;
                        end else if (state_q == ADDR_ACK) begin
`ifdef I2C_MASTER_REG_ADDR_EN
                            state_d = REG;
                            sh_d    = rga_q;
`else
                            state_d = DATA;
                            sh_d    = dat_q;
`endif
                        end else if (state_q == REG_ACK) begin
                            state_d = DATA;
                            sh_d    = dat_q;
                        end else begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: if (qtr_q == 2'd2) begin
                    state_d = IDLE;
                    qtr_d   = 2'd0;
                    done_d  = 1'b1;
                end
                default: ;
            endcase
        end
        // Bus outputs are decoded from the next state so they register in step with it.
        busy_d = state_d != IDLE;
        scl_d  = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            START: oe_d = qtr_d[0];
            ADDR, REG, DATA: begin
                scl_d = qtr_d[1];
                oe_d  = !sh_d[7];
            end
            ADDR_ACK, REG_ACK, DATA_ACK: scl_d = qtr_d[1];
            STOP: begin
                scl_d = qtr_d != 2'd0;
                oe_d  = qtr_d != 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            div_q   <= 16'd0;
            sh_q    <= 8'd0;
            dat_q   <= 8'd0;
            nack_q  <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef I2C_MASTER_REG_ADDR_EN
            rga_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sh_q    <= sh_d;
            dat_q   <= dat_d;
            nack_q  <= nack_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef I2C_MASTER_REG_ADDR_EN
            rga_q   <= rga_d;
`endif
        end
    end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench with a bus-level responder model for i2c_master.
module tb_i2c_master;
    localparam int DIV = 4;
`ifdef I2C_MASTER_REG_ADDR_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    typedef struct packed {
        logic [23:0] b;
        int          n;
        logic        err;
        int          cyc;
    } exp_t;

    logic       clk = 0, rst = 1, start = 0;
    logic [6:0] dev_addr = 0;
    logic [7:0] reg_addr = 0, wr_data = 0;
    logic       scl, busy, done, ack_err;
    wire        sda;
    logic       drv = 0;

    assign sda = drv ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .wr_data(wr_data), .scl(scl), .sda(sda), .busy(busy), .done(done), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    exp_t exp_q[$];

    task automatic chk(input string nm, input longint act, input longint want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // responder: decodes START/STOP/bytes from the bus, ACKs every byte except index nack_idx
    int         bitn = 0, stops = 0, nack_idx = -1, xcnt = 0;
    logic       act = 0, ps = 1, psd = 1;
    logic [7:0] sh = 0;
    logic [7:0] rxq[$];

    always @(negedge clk) begin
        if (sda === 1'bx) xcnt++;
        if (rst) begin
            act = 0; bitn = 0; drv = 0;
        end else if (scl && ps && psd && !sda) begin
            act = 1; bitn = 0; stops = 0; rxq.delete();
        end else if (scl && ps && !psd && sda) begin
            act = 0; stops++;
        end else if (act && scl && !ps) begin
            if (bitn < 8) sh = {sh[6:0], sda};
            bitn++;
            if (bitn == 8) rxq.push_back(sh);
        end else if (act && !scl && ps) begin
            if (bitn == 8) drv = (rxq.size() - 1 != nack_idx);
            if (bitn == 9) begin drv = 0; bitn = 0; end
        end
        ps = scl;
        psd = sda;
    end

    // monitor: on every done pulse, pop the expected transaction and compare
    int   cyc = 0, done_cnt = 0;
    logic pb = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc = (busy && !pb) ? 0 : cyc + 1;
        pb = busy;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("cycles", cyc, e.cyc);
                chk("ack_err", ack_err, e.err);
                chk("stops", stops, 1);
                chk("nbytes", rxq.size(), e.n);
                for (int i = 0; i < rxq.size() && i < e.n; i++) chk("byte", rxq[i], e.b[23-8*i -: 8]);
            end
        end
    end

    task automatic issue(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d, input int nk);
        exp_t e;
        int   k;
        k = (nk < 0) ? NB : nk + 1;
`ifdef I2C_MASTER_REG_ADDR_EN
        e.b = {a, 1'b0, r, d};
`else
        e.b = {a, 1'b0, d, 8'h00};
`endif
        e.n = k;
        e.err = nk >= 0;
        e.cyc = DIV * (5 + 36 * k);
        exp_q.push_back(e);
        nack_idx = nk;
        @(negedge clk);
        dev_addr = a; reg_addr = r; wr_data = d; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic finish_txn(input logic err, input bit poke);
        int d0 = done_cnt;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
            @(negedge clk);
            if (poke && i % 50 == 10) begin
                dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom); start = busy;
            end else start = 0;
        end
        start = 0;
        repeat (4) @(negedge clk);
        chk("one_done", done_cnt - d0, 1);
        chk("busy_idle", busy, 0);
        chk("err_held", ack_err, err);
    endtask

    initial begin
        int i;
        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1); chk("rst_sda", sda, 1); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_err", ack_err, 0);
        rst = 0;
        issue(7'h42, 8'h05, 8'h80, -1); finish_txn(0, 0);
        issue(7'h42, 8'h05, 8'h3C, -1); finish_txn(0, 0);
        issue(7'h42, 8'h05, 8'h80, 0);  finish_txn(1, 0);
        issue(7'h42, 8'h05, 8'hC0, -1); finish_txn(0, 1);
        issue(7'h7F, 8'hFF, 8'h00, NB - 1); finish_txn(1, 0);
        issue(7'h1A, 8'h77, 8'hA5, -1);
        for (i = 0; i < 4000 && !(act && rxq.size() == NB - 1 && bitn == 4); i++) @(negedge clk);
        chk("reach_data_bit3", i < 4000, 1);
        rst = 1;
        #1;
        chk("mid_rst_scl", scl, 1); chk("mid_rst_sda", sda, 1); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0); chk("mid_rst_err", ack_err, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 0;
        issue(7'h1A, 8'h77, 8'hA5, -1); finish_txn(0, 0);
        for (int t = 0; t < 10; t++) begin
            int nk;
            nk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1;
            issue(7'($urandom), 8'($urandom), 8'($urandom), nk);
            finish_txn(nk >= 0, 1'($urandom_range(0, 1)));
        end
        chk("sda_conflict", xcnt, 0);
        chk("leftover_exp", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
